// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NTIMER countdown timers (TCFG/TVAL/TICLR), a TID register and a free-running
// stable counter on the core CSR port. Optional macro TIMER_PRESCALE_EN divides the timer tick.
module csr_timer_bank #(
  parameter int          NTIMER    = 2,
  parameter int          CNT_W     = 32,
  parameter int          STABLE_W  = 64,
  parameter logic [31:0] TID_RESET = 32'h0,
  parameter int          PRESCALE  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [13:0]         addr,
  input  logic [31:0]         we,
  input  logic [31:0]         wdata,
  output logic                hit,
  output logic [31:0]         rdata,
  output logic [NTIMER-1:0]   timer_irq,
  output logic                irq_any,
  output logic [STABLE_W-1:0] cnt_value
);

  // CSR port has no handshake: reads are combinational on addr, and a write commits
  // at the clock edge whenever addr hits and we != 0 (every cycle is a valid beat).

  if (NTIMER < 1 || NTIMER > 8 || CNT_W < 8 || CNT_W > 32 ||
      STABLE_W < 32 || STABLE_W > 64 || PRESCALE < 1) begin : g_param_check
    $error("csr_timer_bank: parameter out of range");
  end

  logic [31:0]         tid_q, tid_d;
  logic [STABLE_W-1:0] cnt_q;
  logic [CNT_W-1:0]    tcfg_q [NTIMER];
  logic [CNT_W-1:0]    tcfg_d [NTIMER];
  logic [CNT_W-1:0]    tval_q [NTIMER];
  logic [CNT_W-1:0]    tval_d [NTIMER];
  logic [NTIMER-1:0]   pend_q, pend_d;

  logic                sel_tid;
  logic [NTIMER-1:0]   sel_cfg, sel_val, sel_clr;
  logic                wr_en;
  logic [31:0]         wdata_m;
  logic                tick;

  function automatic logic [13:0] cfg_addr(input int i);
    return (i == 0) ? 14'h041 : 14'(32'h200 + 4 * i);
  endfunction

  function automatic logic [13:0] val_addr(input int i);
    return (i == 0) ? 14'h042 : 14'(32'h201 + 4 * i);
  endfunction

  function automatic logic [13:0] clr_addr(input int i);
    return (i == 0) ? 14'h044 : 14'(32'h202 + 4 * i);
  endfunction

  always_comb begin
    sel_tid = (addr == 14'h040);
    sel_cfg = '0;
    sel_val = '0;
    sel_clr = '0;
    for (int i = 0; i < NTIMER; i++) begin
      sel_cfg[i] = (addr == cfg_addr(i));
      sel_val[i] = (addr == val_addr(i));
      sel_clr[i] = (addr == clr_addr(i));
    end
  end

  assign hit = sel_tid | (|sel_cfg) | (|sel_val) | (|sel_clr);

  // TICLR and unmapped addresses fall through to zero.
  always_comb begin
    rdata = '0;
    if (sel_tid) rdata = tid_q;
    for (int i = 0; i < NTIMER; i++) begin
      if (sel_cfg[i]) rdata = 32'(tcfg_q[i]);
      if (sel_val[i]) rdata = 32'(tval_q[i]);
    end
  end

  assign wr_en   = |we;
  assign wdata_m = (rdata & ~we) | (wdata & we);

`ifdef TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] ps_q, ps_d;

  // Any TCFG write realigns the shared prescaler so a fresh countdown starts on a full period.
  always_comb begin
    tick = (ps_q == PS_W'(PRESCALE - 1));
    ps_d = tick ? '0 : ps_q + PS_W'(1);
    if (wr_en && (|sel_cfg)) ps_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) ps_q <= '0;
    else         ps_q <= ps_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    tid_d = tid_q;
    if (wr_en && sel_tid) tid_d = wdata_m;
    for (int i = 0; i < NTIMER; i++) begin
      tcfg_d[i] = tcfg_q[i];
      tval_d[i] = tval_q[i];
      pend_d[i] = pend_q[i];
      // Clear first so a same-cycle expiry below re-sets the flag.
      if (wr_en && sel_clr[i] && wdata_m[0]) pend_d[i] = 1'b0;
      if (wr_en && sel_cfg[i]) begin
        tcfg_d[i] = wdata_m[CNT_W-1:0];
        if (wdata_m[0]) tval_d[i] = {wdata_m[CNT_W-1:2], 2'b00};
      end else if (tcfg_q[i][0] && tick) begin
        if (tval_q[i] != '0) begin
          tval_d[i] = tval_q[i] - CNT_W'(1);
        end else begin
          pend_d[i] = 1'b1;
          if (tcfg_q[i][1]) tval_d[i] = {tcfg_q[i][CNT_W-1:2], 2'b00};
          else              tcfg_d[i][0] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tid_q  <= TID_RESET;
      cnt_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < NTIMER; i++) begin
        tcfg_q[i] <= '0;
        tval_q[i] <= '0;
      end
    end else begin
      tid_q  <= tid_d;
      cnt_q  <= cnt_q + STABLE_W'(1);
      pend_q <= pend_d;
      for (int i = 0; i < NTIMER; i++) begin
        tcfg_q[i] <= tcfg_d[i];
        tval_q[i] <= tval_d[i];
      end
    end
  end

  assign timer_irq = pend_q;
  assign irq_any   = |pend_q;
  assign cnt_value = cnt_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: default two-channel instance plus a CNT_W=16 single-channel
// instance sharing addr/wdata but with its own write mask.
module tb_csr_timer_bank;

  logic        clk;
  logic        resetn;
  logic [13:0] addr;
  logic [31:0] we;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic [1:0]  timer_irq;
  logic        irq_any;
  logic [63:0] cnt_value;

  logic [31:0] we16;
  logic        hit16;
  logic [31:0] rdata16;
  logic [0:0]  irq16;
  logic        irq_any16;
  logic [63:0] cnt16;

  logic [63:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  csr_timer_bank #(
    .NTIMER(2), .CNT_W(32), .STABLE_W(64), .TID_RESET(32'h0000_00A5), .PRESCALE(4)
  ) dut (
    .clk(clk), .resetn(resetn), .addr(addr), .we(we), .wdata(wdata),
    .hit(hit), .rdata(rdata), .timer_irq(timer_irq), .irq_any(irq_any),
    .cnt_value(cnt_value)
  );

  csr_timer_bank #(
    .NTIMER(1), .CNT_W(16), .STABLE_W(64), .TID_RESET(32'h0), .PRESCALE(4)
  ) dut16 (
    .clk(clk), .resetn(resetn), .addr(addr), .we(we16), .wdata(wdata),
    .hit(hit16), .rdata(rdata16), .timer_irq(irq16), .irq_any(irq_any16),
    .cnt_value(cnt16)
  );

  // Clock / reset-aware reference for the stable counter
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) exp_cnt <= resetn ? exp_cnt + 64'd1 : 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
    addr  = a;
    we    = m;
    wdata = d;
    @(posedge clk);
    #1;
    we = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, {32'h0, rdata}, {32'h0, exp});
  endtask

  initial begin
    resetn = 1'b0;
    addr   = '0;
    we     = '0;
    wdata  = '0;
    we16   = '0;
    step(3);

    // Reset state
    check("rst_cnt", cnt_value, 64'd0);
    check("rst_irq", {62'h0, timer_irq}, 64'd0);
    check("rst_irq_any", {63'h0, irq_any}, 64'd0);
    chk_rd("rst_tcfg0", 14'h041, 32'h0);
    chk_rd("rst_tval0", 14'h042, 32'h0);
    chk_rd("rst_ticlr0", 14'h044, 32'h0);
    chk_rd("rst_tid", 14'h040, 32'h0000_00A5);
    resetn = 1'b1;
    step(5);
    check("cnt_after5", cnt_value, exp_cnt);
    check("cnt_after5_abs", cnt_value, 64'd5);

    // Decode
    addr = 14'h043; #1;
    check("hit_43", {63'h0, hit}, 64'd0);
    check("rdata_43", {32'h0, rdata}, 64'd0);
    addr = 14'h204; #1;
    check("hit_204", {63'h0, hit}, 64'd1);
    addr = 14'h208; #1;
    check("hit_208", {63'h0, hit}, 64'd0);

    // TID masked write and we=0 no-op
    wr(14'h040, 32'h0000_FF00, 32'h1234_5678);
    chk_rd("tid_masked", 14'h040, 32'h0000_56A5);
    wr(14'h040, 32'h0, 32'hFFFF_FFFF);
    chk_rd("tid_we0", 14'h040, 32'h0000_56A5);

    // One-shot ch0, InitVal=4
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
    chk_rd("os_tval_load", 14'h042, 32'd16);
    step(1);
    chk_rd("os_tval_15", 14'h042, 32'd15);
    step(15);
    chk_rd("os_tval_0", 14'h042, 32'd0);
    check("os_irq_before", {62'h0, timer_irq}, 64'd0);
    step(1);
    check("os_irq_set", {62'h0, timer_irq}, 64'd1);
    check("os_irq_any", {63'h0, irq_any}, 64'd1);
    chk_rd("os_en_cleared", 14'h041, 32'h0000_0010);
    step(3);
    chk_rd("os_tval_hold", 14'h042, 32'd0);
    check("os_irq_held", {62'h0, timer_irq}, 64'd1);
    wr(14'h044, 32'hFFFF_FFFF, 32'h1);
    check("os_irq_clr", {62'h0, timer_irq}, 64'd0);
    check("os_any_clr", {63'h0, irq_any}, 64'd0);

    // Periodic ch1, InitVal=2
    wr(14'h204, 32'hFFFF_FFFF, 32'h0000_000B);
    chk_rd("per_tval_load", 14'h205, 32'd8);
    step(8);
    chk_rd("per_tval_0", 14'h205, 32'd0);
    check("per_irq_before", {62'h0, timer_irq}, 64'd0);
    step(1);
    check("per_irq_set", {62'h0, timer_irq}, 64'd2);
    chk_rd("per_reload", 14'h205, 32'd8);
    wr(14'h206, 32'hFFFF_FFFF, 32'h1);
    check("per_irq_clr", {62'h0, timer_irq}, 64'd0);
    chk_rd("per_tval_7", 14'h205, 32'd7);
    step(7);
    chk_rd("per_tval_0b", 14'h205, 32'd0);
    wr(14'h206, 32'hFFFF_FFFF, 32'h1);
    check("per_set_wins", {62'h0, timer_irq}, 64'd2);
    chk_rd("per_reload2", 14'h205, 32'd8);
    wr(14'h206, 32'hFFFF_FFFF, 32'h1);
    check("per_irq_clr2", {62'h0, timer_irq}, 64'd0);
    wr(14'h204, 32'hFFFF_FFFF, 32'h0);
    chk_rd("per_dis_tval", 14'h205, 32'd7);
    chk_rd("per_dis_tcfg", 14'h204, 32'h0);
    step(5);
    chk_rd("per_frozen", 14'h205, 32'd7);

    // Masked TCFG write on ch0; TVAL write ignored
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0103);
    chk_rd("msk_tcfg_full", 14'h041, 32'h0000_0103);
    chk_rd("msk_tval_full", 14'h042, 32'h0000_0100);
    wr(14'h041, 32'h0000_0002, 32'h0);
    chk_rd("msk_tcfg", 14'h041, 32'h0000_0101);
    chk_rd("msk_tval", 14'h042, 32'h0000_0100);
    wr(14'h042, 32'hFFFF_FFFF, 32'h0000_0055);
    chk_rd("tval_ro", 14'h042, 32'h0000_00FF);
    step(2);
    chk_rd("msk_count", 14'h042, 32'h0000_00FD);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0);
    chk_rd("msk_dis", 14'h042, 32'h0000_00FD);

    // TCFG write on the expiry cycle wins; no pending
    wr(14'h041, 32'hFFFF_FFFF, 32'h1);
    check("wwin_pre", {62'h0, timer_irq}, 64'd0);
    wr(14'h041, 32'hFFFF_FFFF, 32'h1);
    check("wwin_nopend", {62'h0, timer_irq}, 64'd0);
    chk_rd("wwin_tcfg", 14'h041, 32'h1);
    step(1);
    check("wwin_expire", {62'h0, timer_irq}, 64'd1);
    chk_rd("wwin_en0", 14'h041, 32'h0);
    wr(14'h044, 32'hFFFF_FFFF, 32'h1);
    check("wwin_clr", {62'h0, timer_irq}, 64'd0);

    // InitVal=0 periodic expires every tick
    wr(14'h041, 32'hFFFF_FFFF, 32'h3);
    check("iv0_wr", {62'h0, timer_irq}, 64'd0);
    step(1);
    check("iv0_set", {62'h0, timer_irq}, 64'd1);
    wr(14'h044, 32'hFFFF_FFFF, 32'h1);
    check("iv0_set_wins", {62'h0, timer_irq}, 64'd1);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0);
    check("iv0_dis_keeps", {62'h0, timer_irq}, 64'd1);
    wr(14'h044, 32'hFFFF_FFFF, 32'h1);
    check("iv0_clr", {62'h0, timer_irq}, 64'd0);

    // Unmapped write has no effect
    wr(14'h043, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_rd("unmap_tcfg", 14'h041, 32'h0);
    chk_rd("unmap_tid", 14'h040, 32'h0000_56A5);
    check("cnt_mid", cnt_value, exp_cnt);

    // CNT_W=16 instance
    addr  = 14'h041;
    wdata = 32'hFFFF_FFFF;
    we16  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    we16 = '0;
    check("w16_tcfg", {32'h0, rdata16}, {32'h0, 32'h0000_FFFF});
    check("w16_hit", {63'h0, hit16}, 64'd1);
    check("w16_other_dut", {32'h0, rdata}, 64'd0);
    addr = 14'h042; #1;
    check("w16_tval", {32'h0, rdata16}, {32'h0, 32'h0000_FFFC});
    step(1);
    check("w16_tval_dec", {32'h0, rdata16}, {32'h0, 32'h0000_FFFB});
    addr = 14'h204; #1;
    check("w16_hit_ch1", {63'h0, hit16}, 64'd0);
    check("w16_irq", {62'h0, irq_any16, irq16}, 64'd0);
    check("w16_cnt", cnt16, exp_cnt);

    // Reset mid-countdown
    wr(14'h204, 32'hFFFF_FFFF, 32'h0000_000B);
    step(3);
    resetn = 1'b0;
    step(1);
    chk_rd("mrst_tcfg1", 14'h204, 32'h0);
    chk_rd("mrst_tval1", 14'h205, 32'h0);
    chk_rd("mrst_tid", 14'h040, 32'h0000_00A5);
    check("mrst_cnt", cnt_value, 64'd0);
    check("mrst_irq", {62'h0, timer_irq}, 64'd0);
    resetn = 1'b1;
    step(2);
    chk_rd("mrst_frozen", 14'h205, 32'h0);
    check("mrst_cnt_run", cnt_value, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
